// File: rtl/ysyx_24110015_key_lut_pipe_pkg.sv
// Shared types for the key lookup table: table entry and lookup result.
// Pure type/constant definitions, no logic, no latency.
// No flow control here; users own their handshakes.
package ysyx_24110015_key_lut_pipe_pkg;

  localparam int NR_KEY   = 4;
  localparam int KEY_LEN  = 8;
  localparam int DATA_LEN = 32;
  localparam int IDX_LEN  = $clog2(NR_KEY);

  typedef struct packed {
    logic                vld;
    logic [KEY_LEN-1:0]  key;
    logic [DATA_LEN-1:0] data;
  } entry_t;

  typedef struct packed {
    logic                hit;
    logic [IDX_LEN-1:0]  idx;
    logic                multi;
    logic [DATA_LEN-1:0] data;
  } result_t;

endpackage

// File: rtl/ysyx_24110015_key_lut_pipe_if.sv
// Bundle of table-write, lookup-request and lookup-response signals.
// Wires only, no latency.
// Request and response each use valid/ready; writes are fire-and-forget.
interface ysyx_24110015_key_lut_pipe_if;
  import ysyx_24110015_key_lut_pipe_pkg::*;

  logic                wr_en;
  logic [IDX_LEN-1:0]  wr_idx;
  logic [KEY_LEN-1:0]  wr_key;
  logic [DATA_LEN-1:0] wr_data;
  logic                wr_vld;
  logic                clr_all;

  logic                req_valid;
  logic                req_ready;
  logic [KEY_LEN-1:0]  req_key;
  logic [DATA_LEN-1:0] req_default;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_LEN-1:0] rsp_data;
  logic                rsp_hit;
  logic [IDX_LEN-1:0]  rsp_idx;
  logic                rsp_multi;

  modport master (
    output wr_en, wr_idx, wr_key, wr_data, wr_vld, clr_all,
    output req_valid, req_key, req_default, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_hit, rsp_idx, rsp_multi
  );

  modport slave (
    input  wr_en, wr_idx, wr_key, wr_data, wr_vld, clr_all,
    input  req_valid, req_key, req_default, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_hit, rsp_idx, rsp_multi
  );

endinterface

// File: rtl/ysyx_24110015_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest set bit, any-set and two-or-more-set flags.
// Combinational, zero latency.
// No flow control.
module ysyx_24110015_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any   = |vec;
  // Clearing the lowest set bit leaves something only when two or more were set.
  assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/ysyx_24110015_key_lut_pipe.sv
// Runtime-writable key->data table answering lookups with hit/idx/multi/default.
// Latency 2 cycles from request accept to rsp_valid; 1 lookup/cycle sustained.
// Holds up to 2 responses under rsp_ready=0, then drops req_ready.
module ysyx_24110015_key_lut_pipe
  import ysyx_24110015_key_lut_pipe_pkg::*;
#(
  parameter bit HAS_DEFAULT = 1'b1
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_24110015_key_lut_pipe_if.slave bus
);

  entry_t             tbl [NR_KEY];
  logic [NR_KEY-1:0]  match;
  logic [IDX_LEN-1:0] enc_idx;
  logic               enc_any;
  logic               enc_multi;
  result_t            look;
  result_t            s1;
  result_t            s2;
  logic               s1_vld;
  logic               s2_vld;
  logic               req_fire;
  logic               s2_load;

  // Compare the request key against every live entry of the current table.
  always_comb begin
    match = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      match[i] = tbl[i].vld && (tbl[i].key == bus.req_key);
    end
  end

  ysyx_24110015_prio_enc #(
    .N     (NR_KEY),
    .IDX_W (IDX_LEN)
  ) u_prio_enc (
    .vec   (match),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

  // Build the lookup result; a miss reports index 0 and the miss value.
  always_comb begin
    look       = '0;
    look.hit   = enc_any;
    look.idx   = enc_any ? enc_idx : '0;
    look.multi = enc_multi;
    if (enc_any)          look.data = tbl[enc_idx].data;
    else if (HAS_DEFAULT) look.data = bus.req_default;
    else                  look.data = '0;
  end

  assign bus.req_ready = !s1_vld || !s2_vld || bus.rsp_ready;
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign s2_load       = s1_vld && (!s2_vld || bus.rsp_ready);

  // Table update; the lookup above reads the pre-edge table, so same-cycle writes stay invisible to it.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_all) begin
      for (int i = 0; i < NR_KEY; i++) tbl[i].vld <= 1'b0;
    end else if (bus.wr_en && (int'(bus.wr_idx) < NR_KEY)) begin
      tbl[bus.wr_idx] <= {bus.wr_vld, bus.wr_key, bus.wr_data};
    end
  end

  // Stage 1: capture the lookup result on accept, drain when it moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else if (req_fire) begin
      s1_vld <= 1'b1;
      s1     <= look;
    end else if (s2_load) begin
      s1_vld <= 1'b0;
    end
  end

  // Stage 2: output register, frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2     <= '0;
    end else if (s2_load) begin
      s2_vld <= 1'b1;
      s2     <= s1;
    end else if (bus.rsp_ready) begin
      s2_vld <= 1'b0;
    end
  end

  assign bus.rsp_valid = s2_vld;
  assign bus.rsp_data  = s2.data;
  assign bus.rsp_hit   = s2.hit;
  assign bus.rsp_idx   = s2.idx;
  assign bus.rsp_multi = s2.multi;

endmodule

// File: tb/tb_ysyx_24110015_key_lut_pipe.sv
// Self-checking bench: directed scenarios plus random traffic against a table/queue model.
module tb_ysyx_24110015_key_lut_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_24110015_key_lut_pipe_if if1 ();
  ysyx_24110015_key_lut_pipe_if if0 ();

  ysyx_24110015_key_lut_pipe #(.HAS_DEFAULT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  ysyx_24110015_key_lut_pipe #(.HAS_DEFAULT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: plain table plus a queue of expected responses in acceptance order.
  logic        m_vld  [4];
  logic [7:0]  m_key  [4];
  logic [31:0] m_data [4];
  logic [35:0] exp_q [$];
  logic [35:0] log_q [$];
  int          stamp_q [$];
  logic        stall_prev = 1'b0;
  logic [35:0] prev_rsp = '0;

  // Result packing {hit, idx[1:0], multi, data[31:0]}.
  function automatic logic [35:0] model_lookup(input logic [7:0] key, input logic [31:0] dflt);
    int first = -1;
    int cnt = 0;
    logic [1:0] fi;
    for (int i = 0; i < 4; i++) begin
      if (m_vld[i] && m_key[i] == key) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    if (first < 0) return {1'b0, 2'b00, 1'b0, dflt};
    fi = 2'(first);
    return {1'b1, fi, (cnt > 1), m_data[first]};
  endfunction

  // Monitor away from the active edge: what is seen here is what the next edge samples.
  always @(negedge clk) begin
    logic [35:0] cur;
    cur = {if1.rsp_hit, if1.rsp_idx, if1.rsp_multi, if1.rsp_data};
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_vld", {63'd0, if1.rsp_valid}, 64'd1);
        chk("hold_rsp", {28'd0, cur}, {28'd0, prev_rsp});
      end
      if (if1.rsp_valid && if1.rsp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", {63'd0, if1.rsp_valid}, 64'd0);
        else chk("rsp", {28'd0, cur}, {28'd0, exp_q.pop_front()});
        log_q.push_back(cur);
        stamp_q.push_back(cyc);
      end
      if (if1.req_valid && if1.req_ready)
        exp_q.push_back(model_lookup(if1.req_key, if1.req_default));
      if (if1.clr_all) begin
        for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
      end else if (if1.wr_en) begin
        m_vld[if1.wr_idx]  = if1.wr_vld;
        m_key[if1.wr_idx]  = if1.wr_key;
        m_data[if1.wr_idx] = if1.wr_data;
      end
      stall_prev = if1.rsp_valid && !if1.rsp_ready;
      prev_rsp   = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [7:0] key, input logic [31:0] data);
    if1.wr_en = 1'b1; if1.wr_idx = idx; if1.wr_key = key; if1.wr_data = data; if1.wr_vld = 1'b1;
    step();
    if1.wr_en = 1'b0;
  endtask

  // Issue one lookup, return cycles from accept to rsp_valid; caller sits at the response negedge.
  task automatic do_req(input logic [7:0] key, input logic [31:0] dflt, output int lat);
    logic ok;
    ok = 1'b0;
    if1.req_valid = 1'b1; if1.req_key = key; if1.req_default = dflt;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = if1.req_ready;
      step();
    end
    if1.req_valid = 1'b0;
    chk("accept_in_time", {63'd0, ok}, 64'd1);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if1.rsp_valid) begin
        lat = i + 1;
        break;
      end
      step();
    end
  endtask

  initial begin
    int lat;
    logic ok;
    logic rr [4];
    logic [7:0] keys [5];
    keys[0] = 8'h01; keys[1] = 8'h02; keys[2] = 8'h03; keys[3] = 8'h01; keys[4] = 8'h03;

    if1.wr_en = 0; if1.wr_idx = 0; if1.wr_key = 0; if1.wr_data = 0; if1.wr_vld = 0; if1.clr_all = 0;
    if1.req_valid = 0; if1.req_key = 0; if1.req_default = 0; if1.rsp_ready = 1;
    if0.wr_en = 0; if0.wr_idx = 0; if0.wr_key = 0; if0.wr_data = 0; if0.wr_vld = 0; if0.clr_all = 0;
    if0.req_valid = 0; if0.req_key = 0; if0.req_default = 0; if0.rsp_ready = 1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {63'd0, if1.rsp_valid}, 64'd0);
    chk("rst_data",  {32'd0, if1.rsp_data}, 64'd0);
    chk("rst_hit",   {63'd0, if1.rsp_hit}, 64'd0);
    chk("rst_idx",   {62'd0, if1.rsp_idx}, 64'd0);
    chk("rst_multi", {63'd0, if1.rsp_multi}, 64'd0);
    chk("rst_ready", {63'd0, if1.req_ready}, 64'd1);
    step();

    // Miss on empty table, default enabled.
    do_req(8'h77, 32'h1234, lat);
    chk("miss_lat",  lat, 2);
    chk("miss_data", {32'd0, if1.rsp_data}, 64'h1234);
    chk("miss_hit",  {63'd0, if1.rsp_hit}, 64'd0);
    chk("miss_idx",  {62'd0, if1.rsp_idx}, 64'd0);
    step();

    // Miss with default disabled.
    if0.req_valid = 1'b1; if0.req_key = 8'h77; if0.req_default = 32'h1234;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = if0.req_ready;
      step();
    end
    if0.req_valid = 1'b0;
    chk("nodef_accept", {63'd0, ok}, 64'd1);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = if0.rsp_valid;
      if (!ok) step();
    end
    chk("nodef_valid", {63'd0, ok}, 64'd1);
    chk("nodef_data",  {32'd0, if0.rsp_data}, 64'd0);
    chk("nodef_hit",   {63'd0, if0.rsp_hit}, 64'd0);
    step();

    // Basic hit.
    wr(2'd2, 8'h5A, 32'hDEADBEEF);
    do_req(8'h5A, 32'h1234, lat);
    chk("hit_lat",   lat, 2);
    chk("hit_data",  {32'd0, if1.rsp_data}, 64'hDEADBEEF);
    chk("hit_hit",   {63'd0, if1.rsp_hit}, 64'd1);
    chk("hit_idx",   {62'd0, if1.rsp_idx}, 64'd2);
    chk("hit_multi", {63'd0, if1.rsp_multi}, 64'd0);
    step();

    // Multi-hit: lowest index wins.
    wr(2'd1, 8'h10, 32'hA);
    wr(2'd3, 8'h10, 32'hB);
    do_req(8'h10, 32'h1234, lat);
    chk("multi_data",  {32'd0, if1.rsp_data}, 64'hA);
    chk("multi_idx",   {62'd0, if1.rsp_idx}, 64'd1);
    chk("multi_multi", {63'd0, if1.rsp_multi}, 64'd1);
    chk("multi_hit",   {63'd0, if1.rsp_hit}, 64'd1);
    step();

    // Write and lookup of the same key in one cycle, then again next cycle.
    log_q.delete();
    if1.wr_en = 1; if1.wr_idx = 0; if1.wr_key = 8'h22; if1.wr_data = 32'h99; if1.wr_vld = 1;
    if1.req_valid = 1; if1.req_key = 8'h22; if1.req_default = 32'h1234;
    step();
    if1.wr_en = 0;
    step();
    if1.req_valid = 0;
    repeat (5) step();
    chk("haz_cnt", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("haz_first_miss", {63'd0, log_q[0][35]}, 64'd0);
      chk("haz_first_data", {32'd0, log_q[0][31:0]}, 64'h1234);
      chk("haz_second_hit", {63'd0, log_q[1][35]}, 64'd1);
      chk("haz_second_data", {32'd0, log_q[1][31:0]}, 64'h99);
    end

    // clr_all beats a same-cycle write.
    if1.clr_all = 1; if1.wr_en = 1; if1.wr_idx = 1; if1.wr_key = 8'h33; if1.wr_data = 32'h55; if1.wr_vld = 1;
    step();
    if1.clr_all = 0; if1.wr_en = 0;
    do_req(8'h33, 32'h4321, lat);
    chk("clr_wr_hit", {63'd0, if1.rsp_hit}, 64'd0);
    step();
    do_req(8'h5A, 32'h4321, lat);
    chk("clr_old_hit", {63'd0, if1.rsp_hit}, 64'd0);
    chk("clr_old_data", {32'd0, if1.rsp_data}, 64'h4321);
    step();

    // Backpressure: 5 back-to-back requests, consumer stalled for 4 cycles.
    wr(2'd0, 8'h01, 32'h100);
    wr(2'd3, 8'h03, 32'h300);
    log_q.delete();
    stamp_q.delete();
    if1.rsp_ready = 0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          logic acc;
          acc = 1'b0;
          if1.req_valid = 1; if1.req_key = keys[k]; if1.req_default = 32'h77;
          for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = if1.req_ready;
            step();
          end
          chk("bp_accept", {63'd0, acc}, 64'd1);
        end
        if1.req_valid = 0;
      end
      begin
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          rr[c] = if1.req_ready;
        end
        step();
        if1.rsp_ready = 1;
      end
    join
    repeat (6) step();
    chk("bp_ready0", {63'd0, rr[0]}, 64'd1);
    chk("bp_ready1", {63'd0, rr[1]}, 64'd1);
    chk("bp_ready2", {63'd0, rr[2]}, 64'd0);
    chk("bp_ready3", {63'd0, rr[3]}, 64'd0);
    chk("bp_cnt", log_q.size(), 5);
    if (log_q.size() == 5) begin
      chk("bp_r0", {28'd0, log_q[0]}, {28'd0, 1'b1, 2'd0, 1'b0, 32'h100});
      chk("bp_r1", {28'd0, log_q[1]}, {28'd0, 1'b0, 2'd0, 1'b0, 32'h77});
      chk("bp_r2", {28'd0, log_q[2]}, {28'd0, 1'b1, 2'd3, 1'b0, 32'h300});
      for (int i = 1; i < 5; i++) chk("bp_rate", stamp_q[i] - stamp_q[i-1], 1);
    end

    // Reset with both stages full.
    if1.rsp_ready = 0;
    if1.req_valid = 1; if1.req_key = 8'h01; if1.req_default = 32'h5;
    repeat (2) step();
    if1.req_valid = 0;
    @(negedge clk);
    chk("full_before_rst", {62'd0, if1.rsp_valid, if1.req_ready}, 64'd2);
    step();
    rst = 1;
    step();
    rst = 0;
    if1.rsp_ready = 1;
    @(negedge clk);
    chk("mrst_valid", {63'd0, if1.rsp_valid}, 64'd0);
    chk("mrst_outs", {28'd0, if1.rsp_hit, if1.rsp_idx, if1.rsp_multi, if1.rsp_data}, 64'd0);
    step();
    do_req(8'h01, 32'h6, lat);
    chk("mrst_miss_hit", {63'd0, if1.rsp_hit}, 64'd0);
    chk("mrst_miss_data", {32'd0, if1.rsp_data}, 64'h6);
    step();

    // Random traffic checked by the monitor.
    for (int c = 0; c < 400; c++) begin
      if1.wr_en       = ($urandom % 4) == 0;
      if1.wr_idx      = 2'($urandom % 4);
      if1.wr_key      = 8'($urandom % 8);
      if1.wr_data     = $urandom;
      if1.wr_vld      = ($urandom % 4) != 0;
      if1.clr_all     = ($urandom % 40) == 0;
      if1.req_valid   = ($urandom % 2) == 0;
      if1.req_key     = 8'($urandom % 8);
      if1.req_default = $urandom;
      if1.rsp_ready   = ($urandom % 3) != 0;
      step();
    end
    if1.wr_en = 0; if1.clr_all = 0; if1.req_valid = 0; if1.rsp_ready = 1;
    repeat (6) step();
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_key_lut_pipe.md
Name: ysyx_24110015_key_lut_pipe

Overview:
- Programmable, pipelined successor to the combinational key-to-data selector.
- Holds NR_KEY runtime-writable {valid, key, data} entries instead of a fixed lut bus.
- Answers key lookups through a 2-stage valid/ready pipeline and reports hit, hit index, multi-hit and a default value on a miss.
- Used for decoder/CSR/MMIO address-to-attribute lookup where the table changes at runtime and the lookup must be registered for timing.

Parameters:
- NR_KEY, 4, number of table entries (>=2).
- KEY_LEN, 8, key width in bits.
- DATA_LEN, 32, data width in bits.
- HAS_DEFAULT, 1: 1 = a miss returns req_default; 0 = a miss returns all-zero data.
- IDX_LEN, $clog2(NR_KEY), width of entry index (derived; not overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write one table entry this cycle.
- wr_idx  input  IDX_LEN  entry to write; an index >= NR_KEY is ignored.
- wr_key  input  KEY_LEN  key written.
- wr_data  input  DATA_LEN  data written.
- wr_vld  input  1  valid bit written (0 = invalidate entry).
- clr_all  input  1  invalidate every entry.
- req_valid  input  1  lookup request valid.
- req_ready  output  1  lookup request accepted when req_valid && req_ready.
- req_key  input  KEY_LEN  key to look up.
- req_default  input  DATA_LEN  value returned on a miss (HAS_DEFAULT=1).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  DATA_LEN  selected data or the miss value.
- rsp_hit  output  1  at least one valid entry matched.
- rsp_idx  output  IDX_LEN  lowest matching index; 0 on a miss.
- rsp_multi  output  1  two or more valid entries matched.

Behaviour:
- Reset (rst=1 at a clock edge):
  - all entry valid bits are 0; key/data storage does not need a reset value;
  - S1/S2 valid bits are 0;
  - rsp_valid=0, rsp_data=0, rsp_hit=0, rsp_idx=0, rsp_multi=0.
  - A request or write presented in the reset cycle is dropped. Reset mid-lookup discards in-flight responses.
- Table update:
  - wr_en writes {wr_vld, wr_key, wr_data} to entry wr_idx at the clock edge.
  - clr_all clears all valid bits.
  - clr_all and wr_en in the same cycle: clr_all wins and no entry is valid afterwards.
- Snapshot rule:
  - A lookup accepted in cycle T sees the table as it was before the edge ending T.
  - A write in the same cycle T is not visible to that lookup; it is visible to lookups accepted in T+1 onward.
- Stage S1 (captured on accept):
  - compare req_key against every valid entry;
  - select the lowest-index match;
  - register hit, idx, multi and data in the same cycle.
  - Data on a miss: req_default if HAS_DEFAULT=1, otherwise 0.
- Stage S2: output register driving the rsp_* outputs. It holds rsp_* stable while rsp_valid && !rsp_ready.
- Pipeline flow:
  - S2 loads from S1 when S1 is valid and (S2 is empty or rsp_ready=1).
  - S1 loads a new request when it is empty or moving into S2.
  - req_ready = !s1_valid || !s2_valid || rsp_ready. This is combinational from rsp_ready and registered state only; it never depends on req_valid.
- Latency and throughput:
  - Accept in cycle T gives rsp_valid in cycle T+2, with no stall.
  - Sustained throughput is 1 lookup/cycle while rsp_ready=1.
  - With rsp_ready=0, the pipeline holds at most 2 responses and then deasserts req_ready.
- Ordering: responses come out strictly in acceptance order. No response is dropped or duplicated.
- Multi-hit: the lowest index wins; rsp_multi=1 is informational and is not an error.
- Duplicate keys are legal.

Decomposition:
- Shared package: entry typedef {vld, key, data}; the lookup-result typedef {hit, idx, multi, data}; a localparam for IDX_LEN.
- One natural sub-module, ysyx_24110015_prio_enc: parametrised lowest-set-bit encoder (NR_KEY-bit vector in; idx, any and multi out). Combinational, reusable by the MuxKey successors.

Test Plan:
- Reset, then NR_KEY=4. Write entry 2={key 0x5A, data 0xDEADBEEF}, then look up 0x5A with rsp_ready=1. Expect rsp_valid 2 cycles after accept, data 0xDEADBEEF, hit=1, idx=2, multi=0.
- Miss with HAS_DEFAULT=1 and req_default=0x1234: look up 0x77 on an empty table. Expect data 0x1234, hit=0, idx=0. Repeat with HAS_DEFAULT=0 and expect data 0.
- Multi-hit: entries 1 and 3 both have key 0x10 (data 0xA, 0xB). Expect data 0xA, idx=1, multi=1.
- Same-cycle hazards:
  - A write of entry 0={0x22, 0x99} in the cycle a lookup of 0x22 is accepted: that lookup misses, and the next-cycle lookup hits with 0x99.
  - clr_all together with wr_en: after the edge, no entry is valid.
- Backpressure: stream 5 back-to-back requests with rsp_ready=0 for 4 cycles.
  - req_ready drops after 2 accepts.
  - rsp_* stay stable while stalled.
  - All 5 responses arrive in order once rsp_ready=1, at 1/cycle.
- Reset mid-operation: assert rst with S1 and S2 both full. Expect rsp_valid=0 the next cycle, all outputs 0, table empty, and the first new lookup misses.
